// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types for the clock-enable divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } div_state_t;

  localparam int DIV_MIN = 1;

endpackage

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: 50% duty clock-enable divider with glitch-free
// run-time ratio changes applied at full-period boundaries.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIV_RST = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] active_div,
  output logic             pending
);

  div_state_t       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] shadow;
  logic             stop_q;

  logic [WIDTH:0]   eff_div;
  logic [WIDTH:0]   cnt_nxt;
  logic             wrap;
  logic             fall;
  logic             xfer;
  logic             stop_req;
  logic             go_idle;
  logic             apply;

  // Extra bit keeps an all-ones ratio from wrapping the compare.
  always_comb begin
    eff_div  = (active_div == '0) ?
               (WIDTH+1)'(DIV_MIN) :
               {1'b0, active_div};
    cnt_nxt  = {1'b0, cnt} + (WIDTH+1)'(1);
    wrap     = (cnt_nxt == eff_div);
    fall     = wrap && clk_out;
    xfer     = cfg_valid && cfg_ready;
    stop_req = stop_q || !en;
    go_idle  = stop_req && (fall || !clk_out);
    apply    = (state == PEND) && (fall || go_idle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      active_div <= WIDTH'(DIV_RST);
      shadow     <= '0;
      pending    <= 1'b0;
      cfg_ready  <= 1'b1;
      stop_q     <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          clk_out <= 1'b0;
          stop_q  <= 1'b0;
          if (xfer) active_div <= cfg_div;
          if (en) state <= RUN;
        end
        RUN, PEND: begin
          if (go_idle) begin
            state     <= IDLE;
            cnt       <= '0;
            clk_out   <= 1'b0;
            stop_q    <= 1'b0;
            pending   <= 1'b0;
            cfg_ready <= 1'b1;
            if (apply) active_div <= shadow;
            else if (xfer) active_div <= cfg_div;
          end else begin
            // Only reachable high: latch the stop so the phase completes.
            if (!en) stop_q <= 1'b1;
            if (wrap) begin
              cnt     <= '0;
              clk_out <= ~clk_out;
              tick    <= ~clk_out;
            end else begin
              cnt <= cnt_nxt[WIDTH-1:0];
            end
            if (apply) begin
              active_div <= shadow;
              state      <= RUN;
              pending    <= 1'b0;
              cfg_ready  <= 1'b1;
            end else if (xfer) begin
              shadow    <= cfg_div;
              state     <= PEND;
              pending   <= 1'b1;
              cfg_ready <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: phase-length scoreboard plus table-driven
// ratio sweep and hand-written stop/change/reset sequences.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = '0;
  logic       cfg_ready;
  logic       clk_out;
  logic       tick;
  logic [7:0] active_div;
  logic       pending;

  clk_div_ctrl #(.WIDTH(8), .DIV_RST(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .clk_out    (clk_out),
    .tick       (tick),
    .active_div (active_div),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic lvl;
    int   len;
  } phase_t;

  typedef struct {
    logic [7:0] div;
    int         half;
  } vec_t;

  phase_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int run_id = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: measures every clk_out phase and checks tick.
  logic mon_prev = 1'b0;
  int   mon_last = 0;
  int   mon_run = 0;
  phase_t mon_e;
  always @(negedge clk) begin
    chk("tick", int'(tick), int'(clk_out && !mon_prev));
    if (!rst_n) begin
      mon_last = cyc;
    end else if (clk_out !== mon_prev) begin
      if (mon_run != run_id) begin
        mon_run  = run_id;
        mon_last = start_cyc;
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_toggle", int'(clk_out), int'(mon_prev));
      end else begin
        mon_e = exp_q.pop_front();
        chk("phase_level", int'(mon_prev), int'(mon_e.lvl));
        chk("phase_len", cyc - mon_last, mon_e.len);
      end
      mon_last = cyc;
    end
    mon_prev = clk_out;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic lvl, input int len);
    phase_t p;
    p.lvl = lvl;
    p.len = len;
    exp_q.push_back(p);
  endtask

  task automatic drain_to(input int left, input int budget,
                          input string nm);
    int n;
    n = 0;
    while (exp_q.size() > left && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() > left) begin
      chk(nm, exp_q.size(), left);
      exp_q.delete();
    end
  endtask

  task automatic start_run();
    en = 1'b1;
    start_cyc = cyc + 1;
    run_id++;
  endtask

  task automatic idle_cfg(input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_div   = d;
    step();
    cfg_valid = 1'b0;
    chk("idle_active_div", int'(active_div), int'(d));
    chk("idle_pending", int'(pending), 0);
  endtask

  // Called right after a fall is observed, so en drops in the low phase.
  task automatic stop_low(input string nm);
    en = 1'b0;
    repeat (4) step();
    chk({nm, "_stopped_low"}, int'(clk_out), 0);
    chk({nm, "_ready"}, int'(cfg_ready), 1);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{div: 8'd5,   half: 5};
    tbl[1] = '{div: 8'd3,   half: 3};
    tbl[2] = '{div: 8'd0,   half: 1};
    tbl[3] = '{div: 8'd1,   half: 1};
    tbl[4] = '{div: 8'd255, half: 255};
    tbl[5] = '{div: 8'd2,   half: 2};

    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_active_div", int'(active_div), 5);
    chk("rst_pending", int'(pending), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);

    // Default ratio, then change to 3 mid-high, then held 7.
    start_run();
    push(1'b0, 5);
    push(1'b1, 5);
    drain_to(1, 40, "first_rise_timeout");
    cfg_valid = 1'b1;
    cfg_div   = 8'd3;
    push(1'b0, 3);
    push(1'b1, 3);
    push(1'b0, 7);
    push(1'b1, 7);
    step();
    chk("chg_ready_low", int'(cfg_ready), 0);
    chk("chg_pending", int'(pending), 1);
    cfg_div = 8'd7;
    for (int i = 0; i < 20 && !cfg_ready; i++) step();
    chk("chg_ready_back", int'(cfg_ready), 1);
    chk("chg_ready_at_fall", int'(clk_out), 0);
    chk("chg_applied3", int'(active_div), 3);
    step();
    cfg_valid = 1'b0;
    chk("held_pending", int'(pending), 1);
    chk("held_ready_low", int'(cfg_ready), 0);
    drain_to(0, 80, "chg_timeout");
    chk("chg_applied7", int'(active_div), 7);
    stop_low("chg");

    // Ratio sweep from IDLE.
    for (int t = 0; t < 6; t++) begin
      idle_cfg(tbl[t].div);
      start_run();
      for (int p = 0; p < 4; p++) push(p[0], tbl[t].half);
      drain_to(0, 4 * tbl[t].half + 20, "sweep_timeout");
      stop_low("sweep");
    end

    // Stop 2 cycles into the high phase, en re-asserted meanwhile.
    idle_cfg(8'd5);
    start_run();
    push(1'b0, 5);
    drain_to(0, 40, "stop_rise_timeout");
    step();
    en = 1'b0;
    step();
    en = 1'b1;
    chk("stop_still_high", int'(clk_out), 1);
    push(1'b1, 5);
    push(1'b0, 6);
    push(1'b1, 5);
    drain_to(0, 60, "stop_timeout");
    stop_low("restart");

    // Asynchronous reset mid-high with a ratio pending.
    idle_cfg(8'd6);
    start_run();
    push(1'b0, 6);
    drain_to(0, 40, "rst_rise_timeout");
    cfg_valid = 1'b1;
    cfg_div   = 8'd4;
    step();
    cfg_valid = 1'b0;
    chk("pre_rst_pending", int'(pending), 1);
    chk("pre_rst_high", int'(clk_out), 1);
    #1;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("arst_clk_out", int'(clk_out), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_pending", int'(pending), 0);
    chk("arst_active_div", int'(active_div), 5);
    chk("arst_cfg_ready", int'(cfg_ready), 1);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_low", int'(clk_out), 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
